reaction_timer_ctrl: RTL and testbench
======================================

Name: reaction_timer_ctrl

Overview:
- Measurement core of the reaction timer and the producer side of the LED result interface.
- After a start press, waits a pseudo-random delay, lights the GO lamp, then counts elapsed time in two BCD digits until the react press.
- Presents the result as x (ones) and y (tens) with readit held high, which the LED decoder latches and displays.
- Sits between the debounced/synchronized buttons and the LED decoder.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- TICK_HZ, 100, count resolution; one BCD LSB = 1/TICK_HZ s (default 10 ms, range 00-99 = 0.00-0.99 s).
- DELAY_MIN_TICKS, 100, minimum random wait in ticks.
- DELAY_MASK, 8'hFF, mask applied to LFSR value added to the minimum wait.

Ports:
- clk50M  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  start button level, already synchronized and debounced.
- react  in  1  reaction button level, already synchronized and debounced.
- x  out  4  BCD ones digit of result.
- y  out  4  BCD tens digit of result.
- readit  out  1  result-valid level; x and y are stable whenever high.
- go_led  out  1  GO lamp; high while timing.
- busy  out  1  high in WAIT and GO.

Behaviour:
- Clock and reset: one clock, clk50M. rst is synchronous, active-high, sampled on the clk50M rising edge.
- Reset values: x=0, y=0, readit=0, go_led=0, busy=0, state=IDLE, prescaler=0, LFSR=8'h01 (never all-zero).
- Edge detect: registered copies of start and react; a press is a 0->1 transition, one cycle late. Held levels never re-trigger.
- Prescaler: counts 0..CLK_HZ/TICK_HZ-1. It emits a one-cycle tick at terminal count and is cleared on every state entry.
- LFSR: 8-bit maximal-length, taps 8,6,5,4, steps every clock unconditionally.
- IDLE:
  - All outputs 0.
  - start press -> WAIT. Load delay = DELAY_MIN_TICKS + (LFSR & DELAY_MASK), clear BCD counter.
- WAIT:
  - busy=1. Delay decrements per tick; at 0 -> GO.
  - react press is handled per Optional Feature.
  - start press is ignored.
- GO:
  - busy=1, go_led=1. BCD counter increments per tick: ones 9->0 carries into tens.
  - At 99 it saturates (no wrap) and moves to DONE on the next tick.
  - react press -> DONE with the current count.
  - If a tick and a press coincide, the press wins and the count is not incremented.
- DONE:
  - readit=1, x=ones, y=tens, busy=0, go_led=0.
  - x and y are frozen for the whole time readit is high.
  - start press -> WAIT (new trial). readit falls in the same cycle the state leaves DONE, and x/y clear to 0 on that cycle.
- Output registering: all outputs are registered. readit never rises before x/y are valid; x/y are updated on the same edge readit rises.
- Reset mid-operation: returns to IDLE on the next edge from any state. readit drops immediately, so the decoder clears.
- Illegal state encodings recover to IDLE.

Optional Feature:
- Macro: RT_FALSE_START_EN.
- Defined: a react press in WAIT -> DONE with x=4'hE, y=4'hE (false-start code), readit=1.
- Undefined: a react press in WAIT is ignored and the delay continues.

Decomposition:
- Package rt_pkg: state enum (IDLE, WAIT, GO, DONE), BCD_MAX_DIGIT=4'd9, FALSE_START_CODE=4'hE, LFSR tap constant.
- Sub-module bcd2_counter: clr, en (tick), sat flag, ones/tens outputs. Saturates at 99.
- Prescaler, LFSR and FSM stay in the top.

Test Plan:
All scenarios use CLK_HZ=1000, TICK_HZ=100 (tick every 10 clocks), DELAY_MIN_TICKS=2, DELAY_MASK=0.
1. Reset: assert rst 3 cycles mid-GO -> next edge state=IDLE, readit=0, x=y=0, go_led=0.
2. Normal trial: start press, then react press 37 ticks after go_led rises -> readit=1, y=3, x=7, held stable 1000 cycles until next start.
3. Timeout: start, no react -> count saturates 99, then DONE with y=9, x=9, readit=1. No wrap to 00.
4. Tick/press coincidence: react press on the same cycle as tick with count 14 -> result 14, not 15. Held react level gives no second event.
5. Restart from DONE: start press -> readit 0 on the following edge, x=y=0, busy=1, go_led rises after exactly 2 ticks.
6. False start, with RT_FALSE_START_EN defined: react in WAIT -> x=y=4'hE, readit=1. With the macro undefined, the same stimulus -> go_led still rises after 2 ticks.

Source files
------------

// File: rtl/rt_pkg.sv
// Shared types and constants for the reaction timer core.
// Holds the FSM state encoding, BCD limits and the LFSR feedback taps.
package rt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GO   = 2'd2,
    ST_DONE = 2'd3
  } rt_state_e;

  localparam logic [3:0] BCD_MAX_DIGIT    = 4'd9;
  localparam logic [3:0] FALSE_START_CODE = 4'hE;

  // Fibonacci taps 8,6,5,4 (bit 7 is tap 8); maximal length over 255 states.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'h01;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter (00..99) that saturates at 99 instead of wrapping.
// clr_i has priority over en_i; sat_o flags the terminal value.
module bcd2_counter
  import rt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [3:0] ones_o,
  output logic [3:0] tens_o,
  output logic       sat_o
);

  logic [3:0] ones_q;
  logic [3:0] tens_q;

  assign sat_o  = (ones_q == BCD_MAX_DIGIT) && (tens_q == BCD_MAX_DIGIT);
  assign ones_o = ones_q;
  assign tens_o = tens_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
    end else if (en_i && !sat_o) begin
      if (ones_q == BCD_MAX_DIGIT) begin
        ones_q <= 4'd0;
        tens_q <= tens_q + 4'd1;
      end else begin
        ones_q <= ones_q + 4'd1;
      end
    end
  end

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction timer measurement core: random wait, GO lamp, BCD timing, result hand-off.
// Build option RT_FALSE_START_EN: a react press during the wait reports code EE.
module reaction_timer_ctrl
  import rt_pkg::*;
#(
  parameter int         CLK_HZ          = 50000000,
  parameter int         TICK_HZ         = 100,
  parameter int         DELAY_MIN_TICKS = 100,
  parameter logic [7:0] DELAY_MASK      = 8'hFF
) (
  input  logic       clk50M,
  input  logic       rst,
  input  logic       start,
  input  logic       react,
  output logic [3:0] x,
  output logic [3:0] y,
  output logic       readit,
  output logic       go_led,
  output logic       busy,
  output logic [1:0] state
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  rt_state_e   state_q;
  logic [PW-1:0] presc_q;
  logic [7:0]  lfsr_q;
  logic [7:0]  lfsr_d;
  logic [15:0] delay_q;
  logic [15:0] delay_load;
  logic        start_q;
  logic        react_q;
  logic [3:0]  x_q;
  logic [3:0]  y_q;
  logic        readit_q;
  logic        go_q;
  logic        busy_q;

  logic        tick;
  logic        start_press;
  logic        react_press;
  logic        bcd_clr;
  logic        bcd_en;
  logic [3:0]  ones;
  logic [3:0]  tens;
  logic        sat;

  assign tick        = (presc_q == PRESC_LAST);
  assign start_press = start && !start_q;
  assign react_press = react && !react_q;
  assign lfsr_d      = lfsr_next(lfsr_q);
  assign delay_load  = 16'(DELAY_MIN_TICKS) + {8'h00, lfsr_q & DELAY_MASK};

  always_ff @(posedge clk50M) begin
    if (rst) begin
      start_q <= 1'b0;
      react_q <= 1'b0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      start_q <= start;
      react_q <= react;
      lfsr_q  <= lfsr_d;
    end
  end

  // A press that coincides with a tick stops the count before it can advance.
  always_comb begin
    bcd_clr = 1'b0;
    bcd_en  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: bcd_clr = start_press;
      ST_GO:            bcd_en  = tick && !react_press;
      default: begin
        bcd_clr = 1'b0;
        bcd_en  = 1'b0;
      end
    endcase
  end

  bcd2_counter u_bcd (
    .clk    (clk50M),
    .rst    (rst),
    .clr_i  (bcd_clr),
    .en_i   (bcd_en),
    .ones_o (ones),
    .tens_o (tens),
    .sat_o  (sat)
  );

  always_ff @(posedge clk50M) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      delay_q  <= 16'd0;
      x_q      <= 4'd0;
      y_q      <= 4'd0;
      readit_q <= 1'b0;
      go_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          x_q      <= 4'd0;
          y_q      <= 4'd0;
          readit_q <= 1'b0;
          go_q     <= 1'b0;
          busy_q   <= 1'b0;
          if (start_press) begin
            state_q <= ST_WAIT;
            presc_q <= '0;
            delay_q <= delay_load;
            busy_q  <= 1'b1;
          end
        end
        ST_WAIT: begin
`ifdef RT_FALSE_START_EN
          if (react_press) begin
            state_q  <= ST_DONE;
            presc_q  <= '0;
            x_q      <= FALSE_START_CODE;
            y_q      <= FALSE_START_CODE;
            readit_q <= 1'b1;
            busy_q   <= 1'b0;
          end else
`endif
          if (tick) begin
            // A loaded delay of N ticks expires on the Nth tick.
            if (delay_q < 16'd2) begin
              state_q <= ST_GO;
              presc_q <= '0;
              go_q    <= 1'b1;
            end else begin
              delay_q <= delay_q - 16'd1;
            end
          end
        end
        ST_GO: begin
          if (react_press || (tick && sat)) begin
            state_q  <= ST_DONE;
            presc_q  <= '0;
            x_q      <= ones;
            y_q      <= tens;
            readit_q <= 1'b1;
            go_q     <= 1'b0;
            busy_q   <= 1'b0;
          end
        end
        ST_DONE: begin
          if (start_press) begin
            state_q  <= ST_WAIT;
            presc_q  <= '0;
            delay_q  <= delay_load;
            x_q      <= 4'd0;
            y_q      <= 4'd0;
            readit_q <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          presc_q  <= '0;
          x_q      <= 4'd0;
          y_q      <= 4'd0;
          readit_q <= 1'b0;
          go_q     <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign readit = readit_q;
  assign go_led = go_q;
  assign busy   = busy_q;
  assign state  = state_q;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed bench for reaction_timer_ctrl with a result scoreboard keyed on readit rising.
// Scales the clock so one tick is 10 clocks and the random wait is always 2 ticks.
module tb_reaction_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       react;
  logic [3:0] x;
  logic [3:0] y;
  logic       readit;
  logic       go_led;
  logic       busy;
  logic [1:0] state;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;
  logic       readit_prev = 1'b0;

  always #5 clk = ~clk;

  reaction_timer_ctrl #(
    .CLK_HZ          (1000),
    .TICK_HZ         (100),
    .DELAY_MIN_TICKS (2),
    .DELAY_MASK      (8'h00)
  ) dut (
    .clk50M (clk),
    .rst    (rst),
    .start  (start),
    .react  (react),
    .x      (x),
    .y      (y),
    .readit (readit),
    .go_led (go_led),
    .busy   (busy),
    .state  (state)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Polls on negedges; a sig of 0 selects go_led, 1 selects readit.
  task automatic wait_high(input int sig, input int limit, input string tag);
    int n = 0;
    while (((sig == 0) ? go_led : readit) !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (((sig == 0) ? go_led : readit) !== 1'b1) begin
      tests++;
      fails++;
      $error("FAIL %s: observed timeout after %0d cycles expected level 1", tag, limit);
    end
  endtask

  task automatic press_start();
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (readit === 1'b1 && readit_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL result_unexpected: observed %0h%0h expected no result", y, x);
      end else begin
        exp_v = exp_q.pop_front();
        check("result", {y, x}, exp_v);
      end
    end
    readit_prev = readit;
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    react = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state",  8'(state),  8'd0);
    check("rst_readit", 8'(readit), 8'd0);
    check("rst_xy",     {y, x},     8'h00);
    check("rst_go",     8'(go_led), 8'd0);
    check("rst_busy",   8'(busy),   8'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reset asserted in the middle of a GO phase.
    press_start();
    wait_high(0, 100, "go_t1");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midgo_state",  8'(state),  8'd0);
    check("midgo_readit", 8'(readit), 8'd0);
    check("midgo_xy",     {y, x},     8'h00);
    check("midgo_go",     8'(go_led), 8'd0);
    check("midgo_busy",   8'(busy),   8'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Normal trial: press lands 37 ticks into GO, between tick edges.
    press_start();
    wait_high(0, 100, "go_t2");
    repeat (374) @(negedge clk);
    react = 1'b1;
    exp_q.push_back(8'h37);
    wait_high(1, 30, "readit_t2");
    check("t2_go",   8'(go_led), 8'd0);
    check("t2_busy", 8'(busy),   8'd0);
    repeat (10) @(negedge clk);
    react = 1'b0;
    repeat (990) @(negedge clk);
    check("t2_hold_readit", 8'(readit), 8'd1);
    check("t2_hold_xy",     {y, x},     8'h37);

    // Restart from DONE, then exact WAIT length of two ticks.
    start = 1'b1;
    @(negedge clk);
    check("restart_readit", 8'(readit), 8'd0);
    check("restart_xy",     {y, x},     8'h00);
    check("restart_busy",   8'(busy),   8'd1);
    check("restart_state",  8'(state),  8'd1);
    repeat (19) @(negedge clk);
    check("restart_go_early", 8'(go_led), 8'd0);
    @(negedge clk);
    check("restart_go_exact", 8'(go_led), 8'd1);
    start = 1'b0;

    // Press on the same edge as the tick that would make 15.
    repeat (149) @(negedge clk);
    react = 1'b1;
    exp_q.push_back(8'h14);
    wait_high(1, 30, "readit_t4");

    // New trial with react still held: the held level must not end it.
    press_start();
    wait_high(0, 100, "go_held");
    check("held_readit0", 8'(readit), 8'd0);
    repeat (30) @(negedge clk);
    check("held_go",     8'(go_led), 8'd1);
    check("held_readit", 8'(readit), 8'd0);
    react = 1'b0;
    repeat (2) @(negedge clk);
    react = 1'b1;
    exp_q.push_back(8'h03);
    wait_high(1, 30, "readit_held");
    react = 1'b0;

    // Timeout: no react, count saturates at 99 then reports.
    press_start();
    wait_high(0, 100, "go_t3");
    exp_q.push_back(8'h99);
    wait_high(1, 1100, "readit_t3");
    check("t3_go",    8'(go_led), 8'd0);
    check("t3_busy",  8'(busy),   8'd0);
    check("t3_state", 8'(state),  8'd3);
    repeat (50) @(negedge clk);
    check("t3_hold_xy",     {y, x},     8'h99);
    check("t3_hold_readit", 8'(readit), 8'd1);

    // React pressed during WAIT.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    react = 1'b1;
`ifdef RT_FALSE_START_EN
    exp_q.push_back(8'hEE);
    wait_high(1, 30, "readit_fs");
    check("fs_go",   8'(go_led), 8'd0);
    check("fs_busy", 8'(busy),   8'd0);
`else
    repeat (15) @(negedge clk);
    check("fs_go_early", 8'(go_led), 8'd0);
    check("fs_readit",   8'(readit), 8'd0);
    @(negedge clk);
    check("fs_go_exact", 8'(go_led), 8'd1);
`endif
    react = 1'b0;

    rst = 1'b1;
    @(negedge clk);
    check("final_rst_readit", 8'(readit), 8'd0);
    check("final_rst_state",  8'(state),  8'd0);
    check("final_rst_go",     8'(go_led), 8'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    check("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
